div_ctrl: RTL and testbench

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl.sv | 97 +++++++++
 tb/tb_div_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// div_ctrl: sequences divide/modulo requests onto a signed and an unsigned AXI-stream divider IP.
// Optional DIV_CTRL_ZERO_BYPASS_EN answers a zero divisor locally without touching either IP.
module div_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_signed,
  input  logic        req_mod,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        busy,
  output logic [31:0] dvd_tdata,
  output logic [31:0] dvs_tdata,
  output logic        s_dvd_tvalid,
  output logic        s_dvs_tvalid,
  output logic        u_dvd_tvalid,
  output logic        u_dvs_tvalid,
  input  logic        s_dvd_tready,
  input  logic        s_dvs_tready,
  input  logic        u_dvd_tready,
  input  logic        u_dvs_tready,
  input  logic        s_dout_tvalid,
  input  logic        u_dout_tvalid,
  input  logic [63:0] s_dout_tdata,
  input  logic [63:0] u_dout_tdata
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, DRAIN} state_t;
  state_t      r_state;
  logic        r_signed, r_mod, r_dvd_acc, r_dvs_acc;
  logic [31:0] r_src1, r_src2, r_data;
  logic        w_accept, w_send, w_dvd_hs, w_dvs_hs, w_both, w_dout, w_zero;
  logic [31:0] w_result;
`ifdef DIV_CTRL_ZERO_BYPASS_EN
  assign w_zero = req_src2 == '0;
`else
  assign w_zero = 1'b0;
`endif
  assign req_ready    = r_state == IDLE && !flush;
  assign w_accept     = req_valid && req_ready;
  assign w_send       = r_state == ISSUE || r_state == DRAIN;
  assign s_dvd_tvalid = w_send && r_signed && !r_dvd_acc;
  assign s_dvs_tvalid = w_send && r_signed && !r_dvs_acc;
  assign u_dvd_tvalid = w_send && !r_signed && !r_dvd_acc;
  assign u_dvs_tvalid = w_send && !r_signed && !r_dvs_acc;
  assign w_dvd_hs     = (s_dvd_tvalid && s_dvd_tready) || (u_dvd_tvalid && u_dvd_tready);
  assign w_dvs_hs     = (s_dvs_tvalid && s_dvs_tready) || (u_dvs_tvalid && u_dvs_tready);
  assign w_both       = (r_dvd_acc || w_dvd_hs) && (r_dvs_acc || w_dvs_hs);
  assign w_dout       = r_signed ? s_dout_tvalid : u_dout_tvalid;
  assign w_result     = r_signed ? (r_mod ? s_dout_tdata[31:0] : s_dout_tdata[63:32])
                                 : (r_mod ? u_dout_tdata[31:0] : u_dout_tdata[63:32]);
  assign resp_valid   = r_state == DONE;
  assign resp_data    = r_data;
  assign busy         = r_state != IDLE;
  assign dvd_tdata    = r_src1;
  assign dvs_tdata    = r_src2;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_signed  <= 1'b0;
      r_mod     <= 1'b0;
      r_src1    <= '0;
      r_src2    <= '0;
      r_data    <= '0;
      r_dvd_acc <= 1'b0;
      r_dvs_acc <= 1'b0;
    end else begin
      // handshakes already on the bus are recorded even when a flush arrives alongside them
      r_dvd_acc <= r_state != IDLE && (r_dvd_acc || w_dvd_hs);
      r_dvs_acc <= r_state != IDLE && (r_dvs_acc || w_dvs_hs);
      case (r_state)
        IDLE: if (w_accept) begin
          r_signed <= req_signed;
          r_mod    <= req_mod;
          r_src1   <= req_src1;
          r_src2   <= req_src2;
          r_data   <= req_mod ? req_src1 : '1;
          r_state  <= w_zero ? DONE : ISSUE;
        end
        ISSUE: r_state <= flush ? DRAIN : w_both ? WAIT : ISSUE;
        // a result landing with the flush is already the one to discard, so no drain is needed
        WAIT: if (flush) r_state <= w_dout ? IDLE : DRAIN;
        else if (w_dout) begin
          r_data  <= w_result;
          r_state <= DONE;
        end
        DONE: if (flush || resp_ready) r_state <= IDLE;
        DRAIN: if (w_dout && w_both) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: scoreboard bench for div_ctrl; a small behavioural model stands in for both divider IPs.
module tb_div_ctrl;
  logic        clk = 1'b0, reset = 1'b1;
  logic        req_valid = 1'b0, req_signed = 1'b0, req_mod = 1'b0, flush = 1'b0, resp_ready = 1'b1;
  logic [31:0] req_src1 = '0, req_src2 = '0;
  logic        req_ready, resp_valid, busy;
  logic [31:0] resp_data, dvd_tdata, dvs_tdata;
  logic        s_dvd_tvalid, s_dvs_tvalid, u_dvd_tvalid, u_dvs_tvalid;
  logic        s_dvd_tready, s_dvs_tready, u_dvd_tready, u_dvs_tready;
  logic        s_dout_tvalid = 1'b0, u_dout_tvalid = 1'b0;
  logic [63:0] s_dout_tdata = '0, u_dout_tdata = '0;
  int          tests = 0, fails = 0, tv_cnt = 0, n0 = 0;
  logic [31:0] exp_q[$];
  int          dvd_lag = 0, dvs_lag = 0, ip_lat = 2, dvd_cnt = 0, dvs_cnt = 0, m_lat = 0;
  bit          spur = 1'b0, m_ga = 1'b0, m_gb = 1'b0, m_s = 1'b0;
  logic [31:0] m_a = '0, m_b = '0;

  always #5 clk = ~clk;

  div_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_signed(req_signed), .req_mod(req_mod), .req_src1(req_src1), .req_src2(req_src2),
    .flush(flush), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .busy(busy), .dvd_tdata(dvd_tdata), .dvs_tdata(dvs_tdata),
    .s_dvd_tvalid(s_dvd_tvalid), .s_dvs_tvalid(s_dvs_tvalid),
    .u_dvd_tvalid(u_dvd_tvalid), .u_dvs_tvalid(u_dvs_tvalid),
    .s_dvd_tready(s_dvd_tready), .s_dvs_tready(s_dvs_tready),
    .u_dvd_tready(u_dvd_tready), .u_dvs_tready(u_dvs_tready),
    .s_dout_tvalid(s_dout_tvalid), .u_dout_tvalid(u_dout_tvalid),
    .s_dout_tdata(s_dout_tdata), .u_dout_tdata(u_dout_tdata)
  );

  // divider IP model: each channel's tready rises after its tvalid has waited *_lag cycles
  assign s_dvd_tready = dvd_cnt >= dvd_lag;
  assign u_dvd_tready = dvd_cnt >= dvd_lag;
  assign s_dvs_tready = dvs_cnt >= dvs_lag;
  assign u_dvs_tready = dvs_cnt >= dvs_lag;

  function automatic logic [63:0] ip_div(input logic [31:0] a, input logic [31:0] b, input bit s);
    if (b == 0) return {32'hFFFF_FFFF, a};
    if (s) return {32'($signed(a) / $signed(b)), 32'($signed(a) % $signed(b))};
    return {a / b, a % b};
  endfunction

  always @(posedge clk) begin
    s_dout_tvalid <= 1'b0;
    u_dout_tvalid <= 1'b0;
    if (s_dvd_tvalid || u_dvd_tvalid) begin
      if (dvd_cnt >= dvd_lag) begin
        m_a <= dvd_tdata; m_s <= s_dvd_tvalid; m_ga <= 1'b1; dvd_cnt <= 0;
      end else dvd_cnt <= dvd_cnt + 1;
    end
    if (s_dvs_tvalid || u_dvs_tvalid) begin
      if (dvs_cnt >= dvs_lag) begin
        m_b <= dvs_tdata; m_gb <= 1'b1; dvs_cnt <= 0;
      end else dvs_cnt <= dvs_cnt + 1;
    end
    if (m_ga && m_gb) begin
      m_ga <= 1'b0; m_gb <= 1'b0; m_lat <= ip_lat;
    end else if (m_lat == 1) begin
      m_lat <= 0;
      if (m_s) begin
        s_dout_tvalid <= 1'b1; s_dout_tdata <= ip_div(m_a, m_b, 1'b1);
        u_dout_tvalid <= spur; u_dout_tdata <= 64'hDEAD_BEEF_DEAD_BEEF;
      end else begin
        u_dout_tvalid <= 1'b1; u_dout_tdata <= ip_div(m_a, m_b, 1'b0);
        s_dout_tvalid <= spur; s_dout_tdata <= 64'hDEAD_BEEF_DEAD_BEEF;
      end
    end else if (m_lat > 1) m_lat <= m_lat - 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      #1;
      if (s_dvd_tvalid || s_dvs_tvalid || u_dvd_tvalid || u_dvs_tvalid) tv_cnt++;
      if (s_dvd_tvalid || s_dvs_tvalid) chk("unselected_u_tvalid", {31'b0, u_dvd_tvalid || u_dvs_tvalid}, 0);
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_resp: got %h expected no response", resp_data);
        end else chk("resp_data", resp_data, exp_q.pop_front());
      end
    end
  endtask

  task automatic issue(input bit s, input bit m, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!req_ready && n < 300) begin @(negedge clk); n++; end
    if (!req_ready) timeout("issue_req_ready");
    req_valid = 1'b1; req_signed = s; req_mod = m; req_src1 = a; req_src2 = b;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) timeout("wait_idle");
  endtask

  task automatic wait_high(input int which, input string name);
    int n = 0;
    while (!(which == 0 ? resp_valid : which == 1 ? s_dout_tvalid : u_dout_tvalid) && n < 300) begin
      @(negedge clk); n++;
    end
    if (n >= 300) timeout(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_tvalids", {28'b0, s_dvd_tvalid, s_dvs_tvalid, u_dvd_tvalid, u_dvs_tvalid}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("req_ready_idle", {31'b0, req_ready}, 1);
    // signed 7/2, both readies high: ISSUE lasts one cycle
    exp_q.push_back(32'd3);
    issue(1'b1, 1'b0, 32'd7, 32'd2);
    chk("issue_tvalids", {28'b0, s_dvd_tvalid, s_dvs_tvalid, u_dvd_tvalid, u_dvs_tvalid}, 4'b1100);
    @(negedge clk);
    chk("wait_tvalids", {28'b0, s_dvd_tvalid, s_dvs_tvalid, u_dvd_tvalid, u_dvs_tvalid}, 0);
    chk("wait_busy", {31'b0, busy}, 1);
    wait_idle();
    // signed -7/2 with garbage from the unselected IP alongside the real result
    spur = 1'b1;
    exp_q.push_back(32'hFFFF_FFFD);
    issue(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2);
    wait_idle();
    exp_q.push_back(32'hFFFF_FFFF);
    issue(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_idle();
    spur = 1'b0;
    // unsigned 100/7, divisor channel accepted two cycles after the dividend
    dvs_lag = 2;
    exp_q.push_back(32'd14);
    issue(1'b0, 1'b0, 32'd100, 32'd7);
    chk("split_c1", {28'b0, s_dvd_tvalid, s_dvs_tvalid, u_dvd_tvalid, u_dvs_tvalid}, 4'b0011);
    @(negedge clk);
    chk("split_c2", {28'b0, s_dvd_tvalid, s_dvs_tvalid, u_dvd_tvalid, u_dvs_tvalid}, 4'b0001);
    @(negedge clk);
    chk("split_c3", {28'b0, s_dvd_tvalid, s_dvs_tvalid, u_dvd_tvalid, u_dvs_tvalid}, 4'b0001);
    @(negedge clk);
    chk("split_c4", {28'b0, s_dvd_tvalid, s_dvs_tvalid, u_dvd_tvalid, u_dvs_tvalid}, 0);
    wait_idle();
    dvs_lag = 0;
    // flush during WAIT: drained result is never reported
    ip_lat = 8;
    issue(1'b1, 1'b0, 32'd9, 32'd3);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("drain_busy", {31'b0, busy}, 1);
    wait_high(1, "drain_dout");
    chk("drain_busy_at_dout", {31'b0, busy}, 1);
    chk("drain_ready_at_dout", {31'b0, req_ready}, 0);
    @(negedge clk);
    chk("drain_ready_after", {31'b0, req_ready}, 1);
    ip_lat = 2;
    // flush during ISSUE: the pending divisor channel is still presented
    dvs_lag = 3;
    issue(1'b0, 1'b0, 32'd50, 32'd5);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("drain_presents_dvs", {30'b0, u_dvd_tvalid, u_dvs_tvalid}, 2'b01);
    wait_high(2, "drain_issue_dout");
    @(negedge clk);
    chk("drain_issue_idle", {31'b0, busy}, 0);
    dvs_lag = 0;
    // back-pressure in DONE: data stable and new requests refused
    resp_ready = 1'b0;
    exp_q.push_back(32'd2);
    issue(1'b0, 1'b1, 32'd20, 32'd6);
    wait_high(0, "bp_resp_valid");
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_signed = 1'b0; req_mod = 1'b0; req_src1 = 32'd99; req_src2 = 32'd9;
      chk("bp_resp_valid", {31'b0, resp_valid}, 1);
      chk("bp_resp_data", resp_data, 32'd2);
      chk("bp_req_ready", {31'b0, req_ready}, 0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    wait_idle();
    // flush in DONE drops the response
    resp_ready = 1'b0;
    issue(1'b1, 1'b0, 32'd9, 32'd3);
    wait_high(0, "done_flush_resp_valid");
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    resp_ready = 1'b1;
    chk("done_flush_valid", {31'b0, resp_valid}, 0);
    chk("done_flush_busy", {31'b0, busy}, 0);
    // zero divisor
    n0 = tv_cnt;
`ifdef DIV_CTRL_ZERO_BYPASS_EN
    exp_q.push_back(32'h1234_5678);
    issue(1'b0, 1'b1, 32'h1234_5678, 32'd0);
    chk("bypass_valid", {31'b0, resp_valid}, 1);
    chk("bypass_rem", resp_data, 32'h1234_5678);
    wait_idle();
    exp_q.push_back(32'hFFFF_FFFF);
    issue(1'b1, 1'b0, 32'd5, 32'd0);
    chk("bypass_quot", resp_data, 32'hFFFF_FFFF);
    wait_idle();
    chk("bypass_no_tvalid", tv_cnt, n0);
`else
    exp_q.push_back(32'hFFFF_FFFF);
    issue(1'b0, 1'b0, 32'd5, 32'd0);
    wait_idle();
    chk("zero_div_uses_ip", {31'b0, tv_cnt > n0}, 1);
`endif
    // reset while the IP holds a result: it must not surface later
    ip_lat = 6;
    issue(1'b1, 1'b0, 32'd9, 32'd3);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", {31'b0, busy}, 0);
    chk("midrst_resp_data", resp_data, 0);
    repeat (12) @(negedge clk);
    chk("midrst_idle", {31'b0, busy}, 0);
    ip_lat = 2;
    exp_q.push_back(32'd33);
    issue(1'b0, 1'b0, 32'd100, 32'd3);
    wait_idle();
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
